// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master AXI-Lite arbiter (one transaction per grant); define ARB_RR_EN for round-robin
module axi_lite_arbiter #(
  parameter int  ADDR_W = 32,
  parameter int  DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master side, bit/slice index = master id (0 = IFU, 1 = LSU)
  input  logic [1:0]            m_ar_valid_i,
  input  logic [2*ADDR_W-1:0]   m_ar_addr_i,
  output logic [1:0]            m_ar_ready_o,
  output logic [1:0]            m_r_valid_o,
  output logic [2*DATA_W-1:0]   m_r_data_o,
  output logic [3:0]            m_r_resp_o,
  input  logic [1:0]            m_r_ready_i,
  input  logic [1:0]            m_aw_valid_i,
  input  logic [2*ADDR_W-1:0]   m_aw_addr_i,
  output logic [1:0]            m_aw_ready_o,
  input  logic [1:0]            m_w_valid_i,
  input  logic [2*DATA_W-1:0]   m_w_data_i,
  input  logic [2*STRB_W-1:0]   m_w_strb_i,
  output logic [1:0]            m_w_ready_o,
  output logic [1:0]            m_b_valid_o,
  output logic [3:0]            m_b_resp_o,
  input  logic [1:0]            m_b_ready_i,
  // slave side
  output logic                  s_ar_valid_o,
  output logic [ADDR_W-1:0]     s_ar_addr_o,
  input  logic                  s_ar_ready_i,
  input  logic                  s_r_valid_i,
  input  logic [DATA_W-1:0]     s_r_data_i,
  input  logic [1:0]            s_r_resp_i,
  output logic                  s_r_ready_o,
  output logic                  s_aw_valid_o,
  output logic [ADDR_W-1:0]     s_aw_addr_o,
  input  logic                  s_aw_ready_i,
  output logic                  s_w_valid_o,
  output logic [DATA_W-1:0]     s_w_data_o,
  output logic [STRB_W-1:0]     s_w_strb_o,
  input  logic                  s_w_ready_i,
  input  logic                  s_b_valid_i,
  input  logic [1:0]            s_b_resp_i,
  output logic                  s_b_ready_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RD   = 3'b010,
    S_WR   = 3'b100
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;

  // one-shot guards: each address/data beat is forwarded once per grant
  logic   r_ar_done;
  logic   r_aw_done;
  logic   r_w_done;

  logic [1:0] w_req;
  logic       w_win;
  logic       w_grant;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;

  logic [ADDR_W-1:0] w_own_ar_addr;
  logic [ADDR_W-1:0] w_own_aw_addr;
  logic [DATA_W-1:0] w_own_w_data;
  logic [STRB_W-1:0] w_own_w_strb;

  // a master asks for the bus with either address channel; W alone is not a request
  assign w_req   = m_ar_valid_i | m_aw_valid_i;
  assign w_grant = (r_state == S_IDLE) && (|w_req);

`ifdef ARB_RR_EN
  logic r_ptr;

  // on a tie the master that did not win last time goes first
  always_comb begin
    w_win = w_req[1];
    if (&w_req) begin
      w_win = ~r_ptr;
    end
  end

  // remember the last granted master
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr <= 1'b0;
    end else if (w_grant) begin
      r_ptr <= w_win;
    end
  end
`else
  // fixed priority: LSU (master 1) beats IFU (master 0)
  assign w_win = w_req[1];
`endif

  assign w_own_ar_addr = r_owner ? m_ar_addr_i[2*ADDR_W-1:ADDR_W] : m_ar_addr_i[ADDR_W-1:0];
  assign w_own_aw_addr = r_owner ? m_aw_addr_i[2*ADDR_W-1:ADDR_W] : m_aw_addr_i[ADDR_W-1:0];
  assign w_own_w_data  = r_owner ? m_w_data_i[2*DATA_W-1:DATA_W]  : m_w_data_i[DATA_W-1:0];
  assign w_own_w_strb  = r_owner ? m_w_strb_i[2*STRB_W-1:STRB_W]  : m_w_strb_i[STRB_W-1:0];

  assign w_ar_hs = s_ar_valid_o & s_ar_ready_i;
  assign w_r_hs  = s_r_valid_i  & s_r_ready_o;
  assign w_aw_hs = s_aw_valid_o & s_aw_ready_i;
  assign w_w_hs  = s_w_valid_o  & s_w_ready_i;
  assign w_b_hs  = s_b_valid_i  & s_b_ready_o;

  // state and owner registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // beat-accepted flags, cleared whenever the bus is idle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_ar_hs) r_ar_done <= 1'b1;
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // next state: arbitrate in IDLE, hold the grant until the response handshake
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_owner_nxt = w_win;
          // a read pending from the winner is served before its write
          w_state_nxt = m_ar_valid_i[w_win] ? S_RD : S_WR;
        end
      end
      S_RD: begin
        if (w_r_hs) w_state_nxt = S_IDLE;
      end
      S_WR: begin
        if (w_b_hs) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // channel routing: only the owner's channels reach the slave and vice versa
  always_comb begin
    m_ar_ready_o = 2'b00;
    m_r_valid_o  = 2'b00;
    m_r_data_o   = '0;
    m_r_resp_o   = 4'b0000;
    m_aw_ready_o = 2'b00;
    m_w_ready_o  = 2'b00;
    m_b_valid_o  = 2'b00;
    m_b_resp_o   = 4'b0000;
    s_ar_valid_o = 1'b0;
    s_ar_addr_o  = '0;
    s_r_ready_o  = 1'b0;
    s_aw_valid_o = 1'b0;
    s_aw_addr_o  = '0;
    s_w_valid_o  = 1'b0;
    s_w_data_o   = '0;
    s_w_strb_o   = '0;
    s_b_ready_o  = 1'b0;
    case (r_state)
      S_RD: begin
        s_ar_valid_o          = m_ar_valid_i[r_owner] & ~r_ar_done;
        s_ar_addr_o           = w_own_ar_addr;
        m_ar_ready_o[r_owner] = s_ar_ready_i & ~r_ar_done;
        m_r_valid_o[r_owner]  = s_r_valid_i;
        s_r_ready_o           = m_r_ready_i[r_owner];
        if (r_owner) begin
          m_r_data_o[2*DATA_W-1:DATA_W] = s_r_data_i;
          m_r_resp_o[3:2]               = s_r_resp_i;
        end else begin
          m_r_data_o[DATA_W-1:0] = s_r_data_i;
          m_r_resp_o[1:0]        = s_r_resp_i;
        end
      end
      S_WR: begin
        s_aw_valid_o          = m_aw_valid_i[r_owner] & ~r_aw_done;
        s_aw_addr_o           = w_own_aw_addr;
        m_aw_ready_o[r_owner] = s_aw_ready_i & ~r_aw_done;
        s_w_valid_o           = m_w_valid_i[r_owner] & ~r_w_done;
        s_w_data_o            = w_own_w_data;
        s_w_strb_o            = w_own_w_strb;
        m_w_ready_o[r_owner]  = s_w_ready_i & ~r_w_done;
        m_b_valid_o[r_owner]  = s_b_valid_i;
        s_b_ready_o           = m_b_ready_i[r_owner];
        if (r_owner) begin
          m_b_resp_o[3:2] = s_b_resp_i;
        end else begin
          m_b_resp_o[1:0] = s_b_resp_i;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed table-driven bench for axi_lite_arbiter
module tb_axi_lite_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  m_ar_valid_i, m_ar_ready_o, m_r_valid_o, m_r_ready_i;
  logic [63:0] m_ar_addr_i, m_r_data_o, m_aw_addr_i, m_w_data_i;
  logic [3:0]  m_r_resp_o, m_b_resp_o;
  logic [1:0]  m_aw_valid_i, m_aw_ready_o, m_w_valid_i, m_w_ready_o, m_b_valid_o, m_b_ready_i;
  logic [7:0]  m_w_strb_i;
  logic        s_ar_valid_o, s_ar_ready_i, s_r_valid_i, s_r_ready_o;
  logic [31:0] s_ar_addr_o, s_r_data_i, s_aw_addr_o, s_w_data_o;
  logic [1:0]  s_r_resp_i, s_b_resp_i;
  logic        s_aw_valid_o, s_aw_ready_i, s_w_valid_o, s_w_ready_i, s_b_valid_i, s_b_ready_o;
  logic [3:0]  s_w_strb_o;

  always #5 clk_i = ~clk_i;

  axi_lite_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_ar_valid_i(m_ar_valid_i), .m_ar_addr_i(m_ar_addr_i), .m_ar_ready_o(m_ar_ready_o),
    .m_r_valid_o(m_r_valid_o), .m_r_data_o(m_r_data_o), .m_r_resp_o(m_r_resp_o), .m_r_ready_i(m_r_ready_i),
    .m_aw_valid_i(m_aw_valid_i), .m_aw_addr_i(m_aw_addr_i), .m_aw_ready_o(m_aw_ready_o),
    .m_w_valid_i(m_w_valid_i), .m_w_data_i(m_w_data_i), .m_w_strb_i(m_w_strb_i), .m_w_ready_o(m_w_ready_o),
    .m_b_valid_o(m_b_valid_o), .m_b_resp_o(m_b_resp_o), .m_b_ready_i(m_b_ready_i),
    .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_ready_i(s_ar_ready_i),
    .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i), .s_r_ready_o(s_r_ready_o),
    .s_aw_valid_o(s_aw_valid_o), .s_aw_addr_o(s_aw_addr_o), .s_aw_ready_i(s_aw_ready_i),
    .s_w_valid_o(s_w_valid_o), .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o), .s_w_ready_i(s_w_ready_i),
    .s_b_valid_i(s_b_valid_i), .s_b_resp_i(s_b_resp_i), .s_b_ready_o(s_b_ready_o)
  );

  // {s_ar_v, s_r_rdy, s_aw_v, s_w_v, s_b_rdy, m_ar_rdy[1:0], m_r_v[1:0], m_aw_rdy[1:0], m_w_rdy[1:0], m_b_v[1:0]}
  logic [14:0] ctl;
  assign ctl = {s_ar_valid_o, s_r_ready_o, s_aw_valid_o, s_w_valid_o, s_b_ready_o,
                m_ar_ready_o, m_r_valid_o, m_aw_ready_o, m_w_ready_o, m_b_valid_o};

  typedef struct {
    string       name;
    logic [1:0]  ar_v, aw_v, w_v, r_rdy, b_rdy;
    logic [31:0] a0, a1, aw1;
    logic [4:0]  sl;       // {s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid}
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [14:0] e_ctl;
    logic [31:0] e_ar, e_aw;
    logic [63:0] e_rdata;
    logic [7:0]  e_resp;   // {m_b_resp, m_r_resp}
    logic [35:0] e_w;      // {s_w_strb, s_w_data}
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [14:0] K  = 15'd0;
  localparam logic [35:0] W1 = {4'hF, 32'hDEAD_BEEF};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input string nm, input logic [1:0] ar_v, aw_v, w_v, r_rdy, b_rdy,
                     input logic [31:0] a0, a1, aw1, input logic [4:0] sl,
                     input logic [31:0] rdata, input logic [1:0] resp,
                     input logic [14:0] e_ctl, input logic [31:0] e_ar, e_aw,
                     input logic [63:0] e_rdata, input logic [7:0] e_resp, input logic [35:0] e_w);
    vec_t v;
    v.name = nm; v.ar_v = ar_v; v.aw_v = aw_v; v.w_v = w_v; v.r_rdy = r_rdy; v.b_rdy = b_rdy;
    v.a0 = a0; v.a1 = a1; v.aw1 = aw1; v.sl = sl; v.rdata = rdata; v.resp = resp;
    v.e_ctl = e_ctl; v.e_ar = e_ar; v.e_aw = e_aw; v.e_rdata = e_rdata; v.e_resp = e_resp; v.e_w = e_w;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    m_ar_valid_i = v.ar_v;  m_aw_valid_i = v.aw_v;  m_w_valid_i = v.w_v;
    m_r_ready_i  = v.r_rdy; m_b_ready_i  = v.b_rdy;
    m_ar_addr_i  = {v.a1, v.a0};
    m_aw_addr_i  = {v.aw1, 32'h0};
    {s_ar_ready_i, s_r_valid_i, s_aw_ready_i, s_w_ready_i, s_b_valid_i} = v.sl;
    s_r_data_i = v.rdata; s_r_resp_i = v.resp; s_b_resp_i = v.resp;
  endtask

  task automatic clr();
    vec_t z;
    z.ar_v = 0; z.aw_v = 0; z.w_v = 0; z.r_rdy = 0; z.b_rdy = 0;
    z.a0 = 0; z.a1 = 0; z.aw1 = 0; z.sl = 0; z.rdata = 0; z.resp = 0;
    apply(z);
  endtask

  logic exp_m1;

  initial begin
    m_w_data_i = {32'hDEAD_BEEF, 32'h0};
    m_w_strb_i = {4'hF, 4'h0};

    // reset with busy inputs: nothing may leak through
    clr();
    m_ar_valid_i = 2'b11; m_aw_valid_i = 2'b11; m_w_valid_i = 2'b11;
    m_r_ready_i = 2'b11; m_b_ready_i = 2'b11; s_r_valid_i = 1'b1; s_b_valid_i = 1'b1;
    s_r_data_i = 32'hFFFF_FFFF; m_ar_addr_i = {32'h200, 32'h100};
    @(negedge clk_i); @(negedge clk_i); #1;
    chk("reset.ctl", 64'(ctl), 64'h0);
    chk("reset.ar_addr", 64'(s_ar_addr_o), 64'h0);
    chk("reset.rdata", m_r_data_o, 64'h0);
    @(negedge clk_i);
    clr();
    rst_i = 1'b1;

    //   name          ar     aw     w      rr     br     a0            a1        aw1           sl        rdata          resp   ctl                       e_ar          e_aw          e_rdata                  e_resp e_w
    add("idle",        2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("rd_req",      2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 32'h8000_0000,32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("rd_ar",       2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 32'h8000_0000,32'h0,    32'h0,        5'b10000, 32'h0,         2'b00, 15'b11000_01_00_00_00_00, 32'h8000_0000,32'h0,        64'h0,                   8'h00, 36'h0);
    add("rd_wait1",    2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'h8000_0000,32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, 15'b01000_00_00_00_00_00, 32'h8000_0000,32'h0,        64'h0,                   8'h00, 36'h0);
    add("rd_wait2",    2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'h8000_0000,32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, 15'b01000_00_00_00_00_00, 32'h8000_0000,32'h0,        64'h0,                   8'h00, 36'h0);
    add("rd_resp",     2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'h8000_0000,32'h0,    32'h0,        5'b01000, 32'h1234_5678, 2'b00, 15'b01000_00_01_00_00_00, 32'h8000_0000,32'h0,        64'h0000_0000_1234_5678, 8'h00, 36'h0);
    add("rd_idle",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("tie_req",     2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 32'h100,      32'h200,  32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("tie_m1_ar",   2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 32'h100,      32'h200,  32'h0,        5'b10000, 32'h0,         2'b00, 15'b11000_10_00_00_00_00, 32'h200,      32'h0,        64'h0,                   8'h00, 36'h0);
    add("tie_m1_r",    2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 32'h100,      32'h200,  32'h0,        5'b01000, 32'hAAAA_0001, 2'b01, 15'b01000_00_10_00_00_00, 32'h200,      32'h0,        64'hAAAA_0001_0000_0000, 8'h04, 36'h0);
    add("tie_m0_req",  2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 32'h100,      32'h200,  32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("tie_m0_ar",   2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 32'h100,      32'h200,  32'h0,        5'b10000, 32'h0,         2'b00, 15'b11000_01_00_00_00_00, 32'h100,      32'h0,        64'h0,                   8'h00, 36'h0);
    add("tie_m0_r",    2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 32'h100,      32'h200,  32'h0,        5'b01000, 32'h5555_0002, 2'b10, 15'b01000_00_01_00_00_00, 32'h100,      32'h0,        64'h0000_0000_5555_0002, 8'h02, 36'h0);
    add("tie_idle",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("w_early1",    2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 32'h0,        32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("w_early2",    2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 32'h0,        32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("wr_req",      2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 32'h0,        32'h0,    32'h8000_0010,5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("wr_aw_w",     2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 32'h0,        32'h0,    32'h8000_0010,5'b00110, 32'h0,         2'b00, 15'b00111_00_00_10_10_00, 32'h0,        32'h8000_0010,64'h0,                   8'h00, W1);
    add("wr_b",        2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 32'h0,        32'h0,    32'h8000_0010,5'b00001, 32'h0,         2'b00, 15'b00001_00_00_00_00_10, 32'h0,        32'h8000_0010,64'h0,                   8'h00, W1);
    add("wr_idle",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,    32'h0,        5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("both_req",    2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 32'h0,        32'h40,   32'h44,       5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("both_ar",     2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 32'h0,        32'h40,   32'h44,       5'b10000, 32'h0,         2'b00, 15'b11000_10_00_00_00_00, 32'h40,       32'h0,        64'h0,                   8'h00, 36'h0);
    add("both_r",      2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 32'h0,        32'h40,   32'h44,       5'b01000, 32'h0BAD_F00D, 2'b00, 15'b01000_00_10_00_00_00, 32'h40,       32'h0,        64'h0BAD_F00D_0000_0000, 8'h00, 36'h0);
    add("both_wr_req", 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 32'h0,        32'h40,   32'h44,       5'b00000, 32'h0,         2'b00, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);
    add("both_aw",     2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 32'h0,        32'h40,   32'h44,       5'b00100, 32'h0,         2'b00, 15'b00111_00_00_10_00_00, 32'h0,        32'h44,       64'h0,                   8'h00, W1);
    add("both_w",      2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 32'h0,        32'h40,   32'h44,       5'b00110, 32'h0,         2'b00, 15'b00011_00_00_00_10_00, 32'h0,        32'h44,       64'h0,                   8'h00, W1);
    add("both_b",      2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 32'h0,        32'h40,   32'h44,       5'b00001, 32'h0,         2'b11, 15'b00001_00_00_00_00_10, 32'h0,        32'h44,       64'h0,                   8'hC0, W1);
    add("idle_resp",   2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 32'h0,        32'h0,    32'h0,        5'b01001, 32'hFFFF_FFFF, 2'b11, K,                        32'h0,        32'h0,        64'h0,                   8'h00, 36'h0);

    foreach (vq[i]) begin
      @(negedge clk_i);
      apply(vq[i]);
      #1;
      chk({vq[i].name, ".ctl"},   64'(ctl),         64'(vq[i].e_ctl));
      chk({vq[i].name, ".ar"},    64'(s_ar_addr_o), 64'(vq[i].e_ar));
      chk({vq[i].name, ".aw"},    64'(s_aw_addr_o), 64'(vq[i].e_aw));
      chk({vq[i].name, ".rdata"}, m_r_data_o,       vq[i].e_rdata);
      chk({vq[i].name, ".resp"},  64'({m_b_resp_o, m_r_resp_o}), 64'(vq[i].e_resp));
      chk({vq[i].name, ".w"},     64'({s_w_strb_o, s_w_data_o}), 64'(vq[i].e_w));
    end

    // stalled slave: m1 owns the bus, m0 waits, only one AR ever issued
    @(negedge clk_i);
    clr(); m_ar_valid_i = 2'b10; m_ar_addr_i = {32'h300, 32'h104}; m_r_ready_i = 2'b11;
    #1 chk("stall.idle", 64'(ctl), 64'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      m_ar_valid_i = 2'b11; s_ar_ready_i = 1'b0;
      #1 chk("stall.ar", {s_ar_valid_o, m_ar_ready_o, s_ar_addr_o}, {1'b1, 2'b00, 32'h300});
    end
    @(negedge clk_i);
    s_ar_ready_i = 1'b1;
    #1 chk("stall.hs", {s_ar_valid_o, m_ar_ready_o}, {1'b1, 2'b10});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1 chk("stall.no2nd", {s_ar_valid_o, m_ar_ready_o}, {1'b0, 2'b00});
    end
    @(negedge clk_i);
    s_ar_ready_i = 1'b0; s_r_valid_i = 1'b1; m_ar_valid_i = 2'b01;
    #1 chk("stall.r1", 64'(m_r_valid_o), 64'(2'b10));
    @(negedge clk_i);
    s_r_valid_i = 1'b0;
    #1 chk("stall.idle2", 64'(ctl), 64'h0);
    @(negedge clk_i);
    s_ar_ready_i = 1'b1;
    #1 chk("stall.m0ar", {m_ar_ready_o, s_ar_addr_o}, {2'b01, 32'h104});
    @(negedge clk_i);
    s_ar_ready_i = 1'b0; m_ar_valid_i = 2'b00; s_r_valid_i = 1'b1;
    #1 chk("stall.r0", 64'(m_r_valid_o), 64'(2'b01));

    // repeated ties, last grant was m0
    m_ar_addr_i = {32'h200, 32'h100};
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_m1 = (k % 2 == 0);
`else
      exp_m1 = 1'b1;
`endif
      @(negedge clk_i);
      m_ar_valid_i = 2'b11; s_ar_ready_i = 1'b0; s_r_valid_i = 1'b0;
      #1 chk("rep.idle", 64'(ctl), 64'h0);
      @(negedge clk_i);
      s_ar_ready_i = 1'b1;
      #1 chk("rep.grant", {m_ar_ready_o, s_ar_addr_o},
             {exp_m1 ? 2'b10 : 2'b01, exp_m1 ? 32'h200 : 32'h100});
      @(negedge clk_i);
      s_ar_ready_i = 1'b0; s_r_valid_i = 1'b1;
      #1 chk("rep.r", 64'(m_r_valid_o), 64'(exp_m1 ? 2'b10 : 2'b01));
    end
    @(negedge clk_i);
    clr();

    // reset asserted mid-read
    @(negedge clk_i);
    m_ar_valid_i = 2'b01; m_ar_addr_i = {32'h0, 32'h8000_0000}; m_r_ready_i = 2'b01;
    @(negedge clk_i);
    #1 chk("rst.rd", 64'(s_ar_valid_o), 64'h1);
    #2 rst_i = 1'b0; s_r_valid_i = 1'b1;
    #1 chk("rst.ctl", 64'(ctl), 64'h0);
    chk("rst.addr", 64'(s_ar_addr_o), 64'h0);
    @(negedge clk_i);
    s_r_valid_i = 1'b0; rst_i = 1'b1;
    #1 chk("rst.idle", 64'(ctl), 64'h0);
    @(negedge clk_i);
    #1 chk("rst.rearb", {s_ar_valid_o, s_ar_addr_o}, {1'b1, 32'h8000_0000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Two-master, one-slave AXI-Lite arbiter that shares the single memory port between IFU (master 0) and LSU (master 1).
- Grants one whole transaction at a time: a read ends on the R handshake, a write ends on the B handshake.
- Routes the owner's channels to the slave and the slave's responses back to the owner only.

Parameters:
- ADDR_W, 32, address width per master.
- DATA_W, 32, data width; STRB_W = DATA_W/8 (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- m_ar_valid_i  in  2  per-master AR valid, bit index = master id (applies to all m_* ports)
- m_ar_addr_i  in  2*ADDR_W  AR addresses, master n at [n*ADDR_W +: ADDR_W]
- m_ar_ready_o  out  2  AR ready
- m_r_valid_o  out  2  R valid
- m_r_data_o  out  2*DATA_W  R data
- m_r_resp_o  out  4  R resp, 2 bits per master, axi_resp_t encoding
- m_r_ready_i  in  2  R ready
- m_aw_valid_i  in  2  AW valid
- m_aw_addr_i  in  2*ADDR_W  AW addresses
- m_aw_ready_o  out  2  AW ready
- m_w_valid_i  in  2  W valid
- m_w_data_i  in  2*DATA_W  W data
- m_w_strb_i  in  2*STRB_W  W strobes
- m_w_ready_o  out  2  W ready
- m_b_valid_o  out  2  B valid
- m_b_resp_o  out  4  B resp
- m_b_ready_i  in  2  B ready
- s_ar_valid_o / s_ar_addr_o(ADDR_W) / s_ar_ready_i  slave AR channel
- s_r_valid_i / s_r_data_i(DATA_W) / s_r_resp_i(2) / s_r_ready_o  slave R channel
- s_aw_valid_o / s_aw_addr_o(ADDR_W) / s_aw_ready_i  slave AW channel
- s_w_valid_o / s_w_data_o(DATA_W) / s_w_strb_o(STRB_W) / s_w_ready_i  slave W channel
- s_b_valid_i / s_b_resp_i(2) / s_b_ready_o  slave B channel

Behaviour:
- States (one-hot): IDLE, RD, WR. Registers: state, owner (1 bit).
- Reset (rst_i=0, asynchronous): state=IDLE, owner=0, priority pointer=0.
- Reset values of outputs: every valid and ready output is 0. Data, addr and resp outputs are 0 while not granted.
- A master requests when ar_valid or aw_valid is set. If one master raises both in the same cycle, the read is served first.
- IDLE:
  - Winner chosen combinationally. Base scheme is fixed priority, master 1 (LSU) over master 0.
  - Winner with ar_valid -> RD; with aw_valid only -> WR. owner <= winner.
  - Nothing is forwarded in IDLE. Arbitration costs one cycle.
- RD:
  - s_ar_* = owner's AR; m_ar_ready_o[owner] = s_ar_ready_i. At most one AR is accepted per grant: after the AR handshake, s_ar_valid_o is held at 0.
  - R routed to owner: m_r_valid_o[owner] = s_r_valid_i, s_r_ready_o = m_r_ready_i[owner].
  - R handshake -> IDLE.
- WR:
  - Owner's AW and W are forwarded independently; each is blocked after its own handshake.
  - B routed to owner. B handshake -> IDLE.
- The non-owner sees all readies and valids at 0. Its pending valids stay stalled; AXI valid-stability is the master's responsibility.
- Slave responses arriving in IDLE are not routed: s_r_ready_o = s_b_ready_o = 0.
- Request/completion overlap: a request arriving in the same cycle as a completion is arbitrated in the following IDLE cycle.
- Back-to-back throughput is one transaction per (arb cycle + slave latency).
- Reset asserted mid-transaction aborts the grant immediately. The slave is reset together with the arbiter.
- Response resp values are passed through unmodified.

Optional Feature:
- ARB_RR_EN:
  - Defined: round-robin. Pointer = last granted master. On a tie, the other master wins; the pointer updates on each grant.
  - Undefined: fixed priority, LSU over IFU. The pointer logic is not synthesized.

Test Plan:
- Single read: m0 AR addr 0x8000_0000; slave returns data 0x1234_5678, resp OKAY after 3 cycles -> s_ar_valid_o rises 1 cycle after request; m_r_data_o[31:0]=0x1234_5678; state returns to IDLE.
- Simultaneous requests: m0 AR 0x100 and m1 AR 0x200 in the same cycle.
  - Without ARB_RR_EN: 0x200 is served first, then 0x100.
  - With ARB_RR_EN: alternates over repeated ties.
- Write: m1 AW 0x8000_0010, W data 0xDEAD_BEEF strb 0xF, W presented 2 cycles before AW -> both are forwarded in WR; B resp OKAY reaches m1 only; m_b_valid_o[0] stays 0.
- Same master, both valids: m1 AR 0x40 and AW 0x44 together -> read completes first, then the write is granted after one IDLE cycle.
- Stalled slave: s_ar_ready_i held at 0 for 10 cycles while m0 also requests -> m0 ready stays 0 and no second AR is issued.
- Reset mid-read: rst_i low while in RD -> all valids and readies go to 0 immediately; state is IDLE after release.
